inst_fetch_buffer_unit: RTL and testbench
=========================================

// Module: inst_fetch_buffer_unit
// PURPOSE
//  Parametrised fetch front-end; next generation of the way1 PCU+IFU pair.
//  - Generates the PC and drives the I-cache request/dataOk handshake, one request outstanding.
//  - Buffers fetched instructions in a DEPTH-entry FIFO tagged with {instAddr, pID}.
//  - Presents buffered instructions to the decoder through a valid/ready interface.
//  - Jump redirect flushes the FIFO, discards stale cache responses and bumps the pID epoch.
// PARAMETERS
//  ADDR_W    32            instruction address width
//  INST_W    32            instruction width
//  DEPTH     4             FIFO entries; power of 2, >=2
//  PID_W     2             pID (flush epoch) width
//  RESET_PC  32'h8000_0000 first fetch address after reset
// PORTS
//  clk               in   1       clock
//  reset_n           in   1       asynchronous active-low reset
//  jumpFlag_i        in   1       redirect pulse, one cycle
//  jumpAddr_i        in   ADDR_W  redirect target; bits[1:0] forced to 0
//  request_o         out  1       I-cache request
//  instAddr_fetch_o  out  ADDR_W  I-cache address; stable while request_o=1
//  dataOk_i          in   1       I-cache response valid; only sampled while request_o=1
//  inst_fetch_i      in   INST_W  I-cache response data
//  ready_i           in   1       decoder accepts the head entry
//  valid_o           out  1       head entry valid
//  inst_o            out  INST_W  head instruction
//  instAddr_o        out  ADDR_W  head instruction address
//  pID_o             out  PID_W   head entry epoch
//  count_o           out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset state:
//   - request_o=0, valid_o=0, count_o=0, pID=0, pc=RESET_PC, state=IDLE.
//   - inst_o, instAddr_o, pID_o=0 while empty.
//  FSM (request_o = state==REQ || state==DROP):
//   IDLE -> REQ  when count<DEPTH and no jump.
//   IDLE jump:   pc<=target, pID++, FIFO cleared; stays IDLE, then REQ next cycle.
//   REQ, dataOk, no jump:
//     - push {pc, inst_fetch_i, pID}; pc+=4.
//     - stay REQ if post-push/pop count<DEPTH, else IDLE.
//   REQ jump, no dataOk:      -> DROP; pc<=target, pID++, FIFO cleared.
//   REQ jump and dataOk same cycle:
//     - response discarded; -> REQ at target next cycle; pID++, FIFO cleared.
//   DROP:
//     - request_o held at the old address until dataOk; data discarded; -> REQ at pc.
//     - A further jump in DROP updates pc and bumps pID again; state stays DROP.
//  Handshake:
//   - Pop when valid_o && ready_i.
//   - Push and pop in the same cycle allowed at any count, including full.
//   - Jump in the same cycle as pop: jump wins; FIFO empty next cycle.
//  Latency and throughput:
//   - dataOk at cycle t -> entry valid_o at t+1.
//   - Same-cycle dataOk sustains 1 instr/cycle.
//   - instAddr_fetch_o advances the cycle after each accepted response.
//  Arithmetic:
//   - pc increments by 4, modulo 2^ADDR_W; wrap is silent.
//   - pID wraps modulo 2^PID_W.
//   - FIFO pointers are log2(DEPTH) bits and wrap naturally.
//  Reset mid-request: all state returns to reset values. Any late dataOk is ignored,
//  because request_o=0.
// CONFIGURATION
//  FETCH_BYPASS_EN defined:
//   - When FIFO empty, state==REQ and dataOk_i=1, response appears on
//     valid_o/inst_o/instAddr_o/pID_o in the same cycle (combinational).
//   - If ready_i=1, the response is consumed without being written.
//   - Not applied in DROP or on a jump cycle.
//  FETCH_BYPASS_EN undefined: minimum dataOk->valid_o latency is 1 cycle, and
//  valid_o is purely registered.
// TESTING
//  1. Reset release, dataOk=1 every request cycle, ready_i=1 ->
//     addrs 0x8000_0000, _0004, _0008 on valid_o in consecutive cycles; pID_o=0.
//  2. ready_i=0, DEPTH=4, dataOk=1 -> 4 pushes, count_o=4, request_o=0.
//     ready_i=1 for 1 cycle -> request_o=1 next cycle.
//  3. Jump to 0x8000_0103 while FIFO holds 3 entries ->
//     count_o=0 next cycle; next fetch addr 0x8000_0100; pID_o=1.
//  4. Jump while request outstanding, dataOk delayed 3 cycles ->
//     request_o held at old addr; response dropped; next request at target.
//  5. Four jumps -> pID_o wraps 3->0. pc at 0xFFFF_FFFC -> next fetch addr 0x0000_0000.
//  6. FETCH_BYPASS_EN, empty FIFO, dataOk=1 & ready_i=1 ->
//     valid_o=1 same cycle, count_o stays 0. Without the macro -> valid_o one cycle later.

Source files
------------

// File: rtl/inst_fetch_buffer_unit_if.sv
// Fetch-unit bus: jump redirect, I-cache request/response and decoder valid/ready.
// The master modport is the fetch unit; the slave modport is its environment.
interface inst_fetch_buffer_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int PID_W  = 2,
    parameter int CNT_W  = 3
);
    logic              jumpFlag_i;
    logic [ADDR_W-1:0] jumpAddr_i;
    logic              request_o;
    logic [ADDR_W-1:0] instAddr_fetch_o;
    logic              dataOk_i;
    logic [INST_W-1:0] inst_fetch_i;
    logic              ready_i;
    logic              valid_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] instAddr_o;
    logic [PID_W-1:0]  pID_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        input  jumpFlag_i, jumpAddr_i, dataOk_i, inst_fetch_i, ready_i,
        output request_o, instAddr_fetch_o, valid_o, inst_o, instAddr_o, pID_o, count_o
    );

    modport slave (
        output jumpFlag_i, jumpAddr_i, dataOk_i, inst_fetch_i, ready_i,
        input  request_o, instAddr_fetch_o, valid_o, inst_o, instAddr_o, pID_o, count_o
    );
endinterface

// File: rtl/inst_fetch_buffer_unit.sv
// Fetch front-end: PC generation, single-outstanding I-cache request, epoch-tagged FIFO.
// Optional FETCH_BYPASS_EN forwards a response straight to the decoder when the FIFO is empty.
module inst_fetch_buffer_unit #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter int              PID_W    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    inst_fetch_buffer_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic [PID_W-1:0]  pid_q, pid_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [PID_W-1:0]  pid_mem_q  [DEPTH];

    logic              jump_s, accept_s, fifo_nempty_s, push_s, pop_s, valid_s;
    logic [ADDR_W-1:0] target_s, head_addr_s;
    logic [INST_W-1:0] head_inst_s;
    logic [PID_W-1:0]  head_pid_s;

    assign jump_s        = bus.jumpFlag_i;
    assign target_s      = bus.jumpAddr_i & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign accept_s      = (state_q == ST_REQ) && bus.dataOk_i && !jump_s;
    assign fifo_nempty_s = (count_q != {CNT_W{1'b0}});
    assign pop_s         = fifo_nempty_s && bus.ready_i;

`ifdef FETCH_BYPASS_EN
    logic bypass_s;
    assign bypass_s = accept_s && !fifo_nempty_s;
    // A bypassed response the decoder takes immediately never occupies a slot.
    assign push_s   = accept_s && !(bypass_s && bus.ready_i);
`else
    assign push_s   = accept_s;
`endif

    // Next-state for PC, epoch, FIFO bookkeeping and the fetch FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        pid_d       = pid_q;
        wr_ptr_d    = push_s ? wr_ptr_q + PTR_W'(1'b1) : wr_ptr_q;
        rd_ptr_d    = pop_s  ? rd_ptr_q + PTR_W'(1'b1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        if (jump_s) begin
            pc_d     = target_s;
            pid_d    = pid_q + PID_W'(1'b1);
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else if (accept_s) begin
            pc_d = pc_q + ADDR_W'(3'd4);
        end else begin
            pc_d = pc_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (!jump_s && (count_d < FULL_CNT)) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A jump with no response in hand must still retire the old request.
                if (jump_s) begin
                    state_d     = bus.dataOk_i ? ST_REQ : ST_DROP;
                    drop_addr_d = pc_q;
                end else if (bus.dataOk_i) begin
                    state_d = (count_d < FULL_CNT) ? ST_REQ : ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (bus.dataOk_i) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            pid_q       <= {PID_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            pid_q       <= pid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage, written with the address and epoch of the request being answered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= {INST_W{1'b0}};
                addr_mem_q[i] <= {ADDR_W{1'b0}};
                pid_mem_q[i]  <= {PID_W{1'b0}};
            end
        end else if (push_s) begin
            inst_mem_q[wr_ptr_q] <= bus.inst_fetch_i;
            addr_mem_q[wr_ptr_q] <= pc_q;
            pid_mem_q[wr_ptr_q]  <= pid_q;
        end
    end

    // Head-of-queue presentation; zeros when nothing is available.
    always_comb begin
        valid_s     = 1'b0;
        head_inst_s = {INST_W{1'b0}};
        head_addr_s = {ADDR_W{1'b0}};
        head_pid_s  = {PID_W{1'b0}};
        if (fifo_nempty_s) begin
            valid_s     = 1'b1;
            head_inst_s = inst_mem_q[rd_ptr_q];
            head_addr_s = addr_mem_q[rd_ptr_q];
            head_pid_s  = pid_mem_q[rd_ptr_q];
        end else begin
`ifdef FETCH_BYPASS_EN
            if (bypass_s) begin
                valid_s     = 1'b1;
                head_inst_s = bus.inst_fetch_i;
                head_addr_s = pc_q;
                head_pid_s  = pid_q;
            end else begin
                valid_s = 1'b0;
            end
`else
            valid_s = 1'b0;
`endif
        end
    end

    assign bus.request_o        = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign bus.instAddr_fetch_o = (state_q == ST_DROP) ? drop_addr_q : pc_q;
    assign bus.valid_o          = valid_s;
    assign bus.inst_o           = head_inst_s;
    assign bus.instAddr_o       = head_addr_s;
    assign bus.pID_o            = head_pid_s;
    assign bus.count_o          = count_q;
endmodule

// File: tb/tb_inst_fetch_buffer_unit.sv
// Directed bench for inst_fetch_buffer_unit (DEPTH=4); follows FETCH_BYPASS_EN when defined.
module tb_inst_fetch_buffer_unit;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    inst_fetch_buffer_unit_if #(.ADDR_W(32), .INST_W(32), .PID_W(2), .CNT_W(3)) bus ();

    inst_fetch_buffer_unit #(
        .ADDR_W(32), .INST_W(32), .DEPTH(4), .PID_W(2), .RESET_PC(32'h8000_0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.jumpFlag_i   = 1'b0;
        bus.jumpAddr_i   = 32'h0;
        bus.dataOk_i     = 1'b0;
        bus.inst_fetch_i = 32'h0;
        bus.ready_i      = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (bus.request_o !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", bus.request_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", bus.valid_o); end
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count_o); end
        checks++; if (bus.inst_o !== 32'h0 || bus.instAddr_o !== 32'h0 || bus.pID_o !== 2'd0) begin
            errors++; $display("FAIL reset_head got %h/%h/%0d exp 0/0/0", bus.inst_o, bus.instAddr_o, bus.pID_o); end
        checks++; if (bus.instAddr_fetch_o !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got %h exp 80000000", bus.instAddr_fetch_o); end
        reset_n = 1'b1;
    endtask

    task automatic test_stream;
        int off;
`ifdef FETCH_BYPASS_EN
        off = 1;
`else
        off = 0;
`endif
        do_reset();
        step();
        checks++; if (bus.request_o !== 1'b1 || bus.instAddr_fetch_o !== 32'h8000_0000) begin
            errors++; $display("FAIL stream_first_req got %0h@%h exp 1@80000000", bus.request_o, bus.instAddr_fetch_o); end
        bus.dataOk_i = 1'b1;
        bus.ready_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.inst_fetch_i = 32'hC0DE_0000 + 32'(k);
            #1;
`ifndef FETCH_BYPASS_EN
            if (k == 0) begin
                checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL stream_latency got %0h exp 0", bus.valid_o); end
            end
`endif
            if (k >= 1 - off) begin
                checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got %0h exp 1", k, bus.valid_o); end
                checks++; if (bus.instAddr_o !== 32'h8000_0000 + 32'(4 * (k - 1 + off))) begin
                    errors++; $display("FAIL stream_addr k=%0d got %h exp %h", k, bus.instAddr_o, 32'h8000_0000 + 32'(4 * (k - 1 + off))); end
                checks++; if (bus.inst_o !== 32'hC0DE_0000 + 32'(k - 1 + off)) begin
                    errors++; $display("FAIL stream_inst k=%0d got %h exp %h", k, bus.inst_o, 32'hC0DE_0000 + 32'(k - 1 + off)); end
                checks++; if (bus.pID_o !== 2'd0) begin errors++; $display("FAIL stream_pid k=%0d got %0d exp 0", k, bus.pID_o); end
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_fill;
        do_reset();
        bus.dataOk_i     = 1'b1;
        bus.inst_fetch_i = 32'h2000_0000;
        step();
        for (int i = 0; i < 4; i++) step();
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", bus.count_o); end
        checks++; if (bus.request_o !== 1'b0) begin errors++; $display("FAIL fill_req got %0h exp 0", bus.request_o); end
        checks++; if (bus.instAddr_o !== 32'h8000_0000 || bus.valid_o !== 1'b1) begin
            errors++; $display("FAIL fill_head got %0h@%h exp 1@80000000", bus.valid_o, bus.instAddr_o); end
        bus.dataOk_i = 1'b0;
        bus.ready_i  = 1'b1;
        step();
        bus.ready_i  = 1'b0;
        checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL fill_pop_count got %0d exp 3", bus.count_o); end
        checks++; if (bus.request_o !== 1'b1 || bus.instAddr_fetch_o !== 32'h8000_0010) begin
            errors++; $display("FAIL fill_rereq got %0h@%h exp 1@80000010", bus.request_o, bus.instAddr_fetch_o); end
        checks++; if (bus.instAddr_o !== 32'h8000_0004) begin errors++; $display("FAIL fill_head2 got %h exp 80000004", bus.instAddr_o); end
        clear_inputs();
    endtask

    task automatic test_jump_flush;
        do_reset();
        bus.dataOk_i     = 1'b1;
        bus.inst_fetch_i = 32'h3000_0000;
        step();
        for (int i = 0; i < 3; i++) step();
        checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL jf_pre_count got %0d exp 3", bus.count_o); end
        bus.jumpFlag_i = 1'b1;
        bus.jumpAddr_i = 32'h8000_0103;
        bus.ready_i    = 1'b1;
        step();
        clear_inputs();
        #1;
        checks++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0) begin
            errors++; $display("FAIL jf_flush got cnt %0d v %0h exp cnt 0 v 0", bus.count_o, bus.valid_o); end
        checks++; if (bus.request_o !== 1'b1 || bus.instAddr_fetch_o !== 32'h8000_0100) begin
            errors++; $display("FAIL jf_target got %0h@%h exp 1@80000100", bus.request_o, bus.instAddr_fetch_o); end
        bus.dataOk_i     = 1'b1;
        bus.ready_i      = 1'b1;
        bus.inst_fetch_i = 32'h3333_0001;
`ifdef FETCH_BYPASS_EN
        #1;
`else
        step();
`endif
        checks++; if (bus.valid_o !== 1'b1 || bus.instAddr_o !== 32'h8000_0100 || bus.pID_o !== 2'd1 || bus.inst_o !== 32'h3333_0001) begin
            errors++; $display("FAIL jf_entry got %0h %h %0d %h exp 1 80000100 1 33330001", bus.valid_o, bus.instAddr_o, bus.pID_o, bus.inst_o); end
        clear_inputs();
    endtask

    task automatic test_drop;
        do_reset();
        step();
        bus.jumpFlag_i = 1'b1;
        bus.jumpAddr_i = 32'h9000_0000;
        step();
        bus.jumpFlag_i = 1'b0;
        checks++; if (bus.request_o !== 1'b1 || bus.instAddr_fetch_o !== 32'h8000_0000) begin
            errors++; $display("FAIL drop_hold1 got %0h@%h exp 1@80000000", bus.request_o, bus.instAddr_fetch_o); end
        bus.jumpFlag_i = 1'b1;
        bus.jumpAddr_i = 32'hA000_0000;
        step();
        bus.jumpFlag_i = 1'b0;
        step();
        checks++; if (bus.request_o !== 1'b1 || bus.instAddr_fetch_o !== 32'h8000_0000) begin
            errors++; $display("FAIL drop_hold2 got %0h@%h exp 1@80000000", bus.request_o, bus.instAddr_fetch_o); end
        bus.dataOk_i     = 1'b1;
        bus.ready_i      = 1'b1;
        bus.inst_fetch_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL drop_no_bypass got %0h exp 0", bus.valid_o); end
        step();
        bus.dataOk_i = 1'b0;
        #1;
        checks++; if (bus.request_o !== 1'b1 || bus.instAddr_fetch_o !== 32'hA000_0000) begin
            errors++; $display("FAIL drop_target got %0h@%h exp 1@a0000000", bus.request_o, bus.instAddr_fetch_o); end
        checks++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0) begin
            errors++; $display("FAIL drop_discard got cnt %0d v %0h exp 0 0", bus.count_o, bus.valid_o); end
        bus.dataOk_i     = 1'b1;
        bus.inst_fetch_i = 32'h4444_0001;
`ifdef FETCH_BYPASS_EN
        #1;
`else
        step();
`endif
        checks++; if (bus.valid_o !== 1'b1 || bus.instAddr_o !== 32'hA000_0000 || bus.pID_o !== 2'd2 || bus.inst_o !== 32'h4444_0001) begin
            errors++; $display("FAIL drop_entry got %0h %h %0d %h exp 1 a0000000 2 44440001", bus.valid_o, bus.instAddr_o, bus.pID_o, bus.inst_o); end
        clear_inputs();
    endtask

    task automatic test_wrap;
        do_reset();
        step();
        for (int j = 0; j < 3; j++) begin
            bus.jumpFlag_i = 1'b1;
            bus.jumpAddr_i = 32'hB000_0000 + 32'(j * 256);
            bus.dataOk_i   = 1'b1;
            step();
        end
        bus.jumpFlag_i   = 1'b0;
        bus.inst_fetch_i = 32'h5300_0000;
        checks++; if (bus.instAddr_fetch_o !== 32'hB000_0200 || bus.count_o !== 3'd0) begin
            errors++; $display("FAIL wrap_req3 got %h cnt %0d exp b0000200 cnt 0", bus.instAddr_fetch_o, bus.count_o); end
        step();
        checks++; if (bus.count_o !== 3'd1 || bus.pID_o !== 2'd3 || bus.instAddr_o !== 32'hB000_0200) begin
            errors++; $display("FAIL wrap_pid3 got cnt %0d pid %0d %h exp 1 3 b0000200", bus.count_o, bus.pID_o, bus.instAddr_o); end
        bus.jumpFlag_i = 1'b1;
        bus.jumpAddr_i = 32'hFFFF_FFFF;
        step();
        bus.jumpFlag_i = 1'b0;
        bus.dataOk_i   = 1'b0;
        #1;
        checks++; if (bus.count_o !== 3'd0 || bus.instAddr_fetch_o !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_jump got cnt %0d %h exp 0 fffffffc", bus.count_o, bus.instAddr_fetch_o); end
        bus.dataOk_i     = 1'b1;
        bus.inst_fetch_i = 32'h5555_5555;
        step();
        bus.dataOk_i = 1'b0;
        #1;
        checks++; if (bus.instAddr_o !== 32'hFFFF_FFFC || bus.pID_o !== 2'd0 || bus.inst_o !== 32'h5555_5555) begin
            errors++; $display("FAIL wrap_pid0 got %h pid %0d %h exp fffffffc 0 55555555", bus.instAddr_o, bus.pID_o, bus.inst_o); end
        checks++; if (bus.instAddr_fetch_o !== 32'h0000_0000) begin
            errors++; $display("FAIL wrap_pc got %h exp 00000000", bus.instAddr_fetch_o); end
        clear_inputs();
    endtask

    task automatic test_bypass;
        do_reset();
        step();
        bus.dataOk_i     = 1'b1;
        bus.ready_i      = 1'b1;
        bus.inst_fetch_i = 32'h6666_0000;
        #1;
`ifdef FETCH_BYPASS_EN
        checks++; if (bus.valid_o !== 1'b1 || bus.inst_o !== 32'h6666_0000 || bus.instAddr_o !== 32'h8000_0000) begin
            errors++; $display("FAIL byp_same got %0h %h %h exp 1 66660000 80000000", bus.valid_o, bus.inst_o, bus.instAddr_o); end
`else
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL byp_same got %0h exp 0", bus.valid_o); end
`endif
        step();
        bus.dataOk_i = 1'b0;
        bus.ready_i  = 1'b0;
        #1;
`ifdef FETCH_BYPASS_EN
        checks++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0) begin
            errors++; $display("FAIL byp_after got cnt %0d v %0h exp 0 0", bus.count_o, bus.valid_o); end
`else
        checks++; if (bus.count_o !== 3'd1 || bus.valid_o !== 1'b1 || bus.inst_o !== 32'h6666_0000) begin
            errors++; $display("FAIL byp_after got cnt %0d v %0h %h exp 1 1 66660000", bus.count_o, bus.valid_o, bus.inst_o); end
`endif
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        step();
        checks++; if (bus.request_o !== 1'b1) begin errors++; $display("FAIL mid_req_pre got %0h exp 1", bus.request_o); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.request_o !== 1'b0) begin errors++; $display("FAIL mid_req_async got %0h exp 0", bus.request_o); end
        bus.dataOk_i     = 1'b1;
        bus.ready_i      = 1'b1;
        bus.inst_fetch_i = 32'h7777_0000;
        step();
        checks++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0 || bus.request_o !== 1'b0) begin
            errors++; $display("FAIL mid_late_ok got cnt %0d v %0h r %0h exp 0 0 0", bus.count_o, bus.valid_o, bus.request_o); end
        clear_inputs();
        reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_stream();
        test_fill();
        test_jump_flush();
        test_drop();
        test_wrap();
        test_bypass();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
